// File: rtl/data_mem_resp.sv
// Data-memory responder: word-organised little-endian RAM behind a request/response
// valid/ready pair, with byte/half/word lanes, sign/zero extension and wait states.
module data_mem_resp #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [32:0] ADDR_LIMIT = 33'(4 * DEPTH_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   wait_cnt;

    logic               cap_we;
    logic [31:0]        cap_addr;
    logic [31:0]        cap_wdata;
    logic [1:0]         cap_size;
    logic               cap_unsigned;

    logic [31:0]        mem [DEPTH_WORDS];

    logic               acc_we;
    logic [31:0]        acc_addr;
    logic [31:0]        acc_wdata;
    logic [1:0]         acc_size;
    logic               acc_unsigned;
    logic [IDX_W-1:0]   idx;
    logic [1:0]         lane;
    logic               misaligned;
    logic               out_of_range;
    logic               acc_err;
    logic               enter_resp;
    logic [31:0]        rd_word;
    logic [7:0]         sel_byte;
    logic [15:0]        sel_half;
    logic [31:0]        load_data;
    logic [3:0]         wr_be;
    logic [31:0]        wr_data;

    // With zero wait states the access happens on the accept edge itself, so the
    // live request fields are used instead of the not-yet-captured copies.
    always_comb begin
        acc_we       = cap_we;
        acc_addr     = cap_addr;
        acc_wdata    = cap_wdata;
        acc_size     = cap_size;
        acc_unsigned = cap_unsigned;
        if (state == ST_IDLE) begin
            acc_we       = req_we;
            acc_addr     = req_addr;
            acc_wdata    = req_wdata;
            acc_size     = req_size;
            acc_unsigned = req_unsigned;
        end
    end

    assign idx          = acc_addr[IDX_W+1:2];
    assign lane         = acc_addr[1:0];
    assign misaligned   = ((acc_size == 2'b01) && acc_addr[0]) ||
                          (((acc_size == 2'b00) || (acc_size == 2'b11)) && (acc_addr[1:0] != 2'b00));
    assign out_of_range = ({1'b0, acc_addr} >= ADDR_LIMIT);
    assign acc_err      = misaligned || out_of_range;
    assign enter_resp   = ((state == ST_WAIT) && (wait_cnt == '0)) ||
                          ((state == ST_IDLE) && req_valid && (WAIT_CYCLES == 0));

    assign rd_word  = mem[idx];
    assign sel_byte = rd_word[{lane, 3'b000} +: 8];
    assign sel_half = rd_word[{acc_addr[1], 4'b0000} +: 16];

    always_comb begin
        load_data = rd_word;
        wr_be     = 4'b1111;
        wr_data   = acc_wdata;
        case (acc_size)
            2'b10: begin
                load_data = acc_unsigned ? {24'h0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
                wr_be     = 4'b0001 << lane;
                wr_data   = {4{acc_wdata[7:0]}};
            end
            2'b01: begin
                load_data = acc_unsigned ? {16'h0, sel_half} : {{16{sel_half[15]}}, sel_half};
                wr_be     = acc_addr[1] ? 4'b1100 : 4'b0011;
                wr_data   = {2{acc_wdata[15:0]}};
            end
            default: begin
                load_data = rd_word;
                wr_be     = 4'b1111;
                wr_data   = acc_wdata;
            end
        endcase
    end

    // RAM is never cleared; a store commits only on the edge entering RESP.
    always_ff @(posedge clk) begin
        if (!rst && enter_resp && acc_we && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    mem[idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            wait_cnt     <= '0;
            req_ready    <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= 32'h0;
            rsp_err      <= 1'b0;
            cap_we       <= 1'b0;
            cap_addr     <= 32'h0;
            cap_wdata    <= 32'h0;
            cap_size     <= 2'b00;
            cap_unsigned <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        cap_we       <= req_we;
                        cap_addr     <= req_addr;
                        cap_wdata    <= req_wdata;
                        cap_size     <= req_size;
                        cap_unsigned <= req_unsigned;
                        req_ready    <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state <= ST_RESP;
                        end else begin
                            state    <= ST_WAIT;
                            wait_cnt <= CNT_W'(WAIT_CYCLES - 1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == '0) begin
                        state <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        req_ready <= 1'b1;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= 32'h0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
            if (enter_resp) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= (acc_err || acc_we) ? 32'h0 : load_data;
                rsp_err   <= acc_err;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_resp.sv
// Bench for data_mem_resp: two instances (2 and 0 wait states) checked against a
// byte-addressed memory model, plus directed literal expectations.
module tb_data_mem_resp;

    localparam int DEPTH = 64;
    localparam int W0    = 2;
    localparam int W1    = 0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst          [2];
    logic        req_valid    [2];
    logic        req_ready    [2];
    logic        req_we       [2];
    logic [31:0] req_addr     [2];
    logic [31:0] req_wdata    [2];
    logic [1:0]  req_size     [2];
    logic        req_unsigned [2];
    logic        rsp_valid    [2];
    logic        rsp_ready    [2];
    logic [31:0] rsp_rdata    [2];
    logic        rsp_err      [2];

    int nChecks = 0;
    int nFails  = 0;

    logic [7:0] mb [2][4*DEPTH];
    exp_t q0[$];
    exp_t q1[$];
    bit   busy   [2];
    bit   inResp [2];
    int   lat    [2];

    data_mem_resp #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W0)) dut0 (
        .clk(clk), .rst(rst[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_size(req_size[0]),
        .req_unsigned(req_unsigned[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    data_mem_resp #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W1)) dut1 (
        .clk(clk), .rst(rst[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_size(req_size[1]),
        .req_unsigned(req_unsigned[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        nChecks++;
        if (act !== expv) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic expv);
        checkOutput(name, {31'h0, act}, {31'h0, expv});
    endtask

    task automatic timeoutFail(input string name);
        nChecks++;
        nFails++;
        $display("[TB] FAIL %s: timed out, expected a handshake", name);
    endtask

    // Byte-granular reference: an access is n consecutive bytes at addr.
    function automatic exp_t modelAccess(input int d, input logic we, input logic [31:0] addr,
                                         input logic [31:0] wdata, input logic [1:0] size,
                                         input logic uns);
        int          n;
        exp_t        e;
        logic [31:0] val;
        n       = (size == 2'b01) ? 2 : ((size == 2'b10) ? 1 : 4);
        e.rdata = 32'h0;
        e.err   = ((addr % 32'(n)) != 0) || (addr >= 32'(4*DEPTH));
        val     = 32'h0;
        if (!e.err) begin
            for (int k = 0; k < n; k++) begin
                if (we) mb[d][int'(addr) + k] = wdata[8*k +: 8];
                else    val[8*k +: 8] = mb[d][int'(addr) + k];
            end
            for (int k = n; k < 4; k++) begin
                val[8*k +: 8] = uns ? 8'h00 : {8{val[8*n-1]}};
            end
            if (!we) e.rdata = val;
        end
        return e;
    endfunction

    function automatic void pushExp(input int d, input exp_t e);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endfunction

    function automatic bit frontExp(input int d, output exp_t e);
        e = '0;
        if (d == 0) begin
            if (q0.size() == 0) return 1'b0;
            e = q0[0];
        end else begin
            if (q1.size() == 0) return 1'b0;
            e = q1[0];
        end
        return 1'b1;
    endfunction

    function automatic void popExp(input int d);
        if (d == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
    endfunction

    function automatic void clearExp(input int d);
        if (d == 0) q0.delete();
        else        q1.delete();
    endfunction

    // Cycle-by-cycle comparison of both instances against the expected-response queues.
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (rst[d]) begin
                busy[d]   = 1'b0;
                inResp[d] = 1'b0;
                clearExp(d);
            end else begin
                if (busy[d] && !inResp[d]) lat[d]++;
                if (busy[d]) begin
                    checkBit("busy_req_ready", req_ready[d], 1'b0);
                end else begin
                    checkBit("idle_rsp_valid", rsp_valid[d], 1'b0);
                    if (req_valid[d] && req_ready[d]) begin
                        busy[d] = 1'b1;
                        lat[d]  = 0;
                    end
                end
                if (busy[d] && rsp_valid[d]) begin
                    if (!inResp[d]) checkOutput("rsp_latency", 32'(lat[d]), 32'((d == 0 ? W0 : W1) + 1));
                    inResp[d] = 1'b1;
                    if (!frontExp(d, e)) begin
                        timeoutFail("rsp_without_expectation");
                    end else begin
                        checkOutput("rsp_rdata", rsp_rdata[d], e.rdata);
                        checkBit("rsp_err", rsp_err[d], e.err);
                    end
                    if (rsp_ready[d]) begin
                        popExp(d);
                        busy[d]   = 1'b0;
                        inResp[d] = 1'b0;
                    end
                end else if (busy[d] && lat[d] > 30) begin
                    timeoutFail("rsp_valid_rise");
                    busy[d] = 1'b0;
                end
            end
        end
    end

    task automatic applyStimulus(input int d, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [1:0] size, input logic uns);
        req_we[d]       = we;
        req_addr[d]     = addr;
        req_wdata[d]    = wdata;
        req_size[d]     = size;
        req_unsigned[d] = uns;
        req_valid[d]    = 1'b1;
    endtask

    task automatic waitAccept(input int d, output int n);
        n = 0;
        while (1) begin
            @(negedge clk);
            n++;
            if (req_ready[d]) break;
            if (n >= 40) begin
                timeoutFail("req_accept");
                break;
            end
        end
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
    endtask

    task automatic waitResp(input int d, input bit randReady, output logic [31:0] rd, output logic er);
        int n;
        n  = 0;
        rd = 32'h0;
        er = 1'b0;
        while (1) begin
            @(negedge clk);
            if (rsp_valid[d] && rsp_ready[d]) begin
                rd = rsp_rdata[d];
                er = rsp_err[d];
                break;
            end
            n++;
            if (n > 60) begin
                timeoutFail("rsp_handshake");
                break;
            end
            @(posedge clk);
            #1;
            if (randReady) rsp_ready[d] = 1'($urandom_range(0, 1));
        end
        @(posedge clk);
        #1;
        rsp_ready[d] = 1'b1;
    endtask

    task automatic runTxn(input int d, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] size, input logic uns, input bit randReady,
                          output logic [31:0] rd, output logic er);
        int n;
        pushExp(d, modelAccess(d, we, addr, wdata, size, uns));
        applyStimulus(d, we, addr, wdata, size, uns);
        waitAccept(d, n);
        waitResp(d, randReady, rd, er);
    endtask

    task automatic expectTxn(input string name, input int d, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                             input logic [31:0] expRd, input logic expErr);
        logic [31:0] rd;
        logic        er;
        runTxn(d, we, addr, wdata, size, uns, 1'b0, rd, er);
        checkOutput({name, "_rdata"}, rd, expRd);
        checkBit({name, "_err"}, er, expErr);
    endtask

    task automatic checkIdle(input string name, input int d);
        checkBit({name, "_req_ready"}, req_ready[d], 1'b1);
        checkBit({name, "_rsp_valid"}, rsp_valid[d], 1'b0);
        checkOutput({name, "_rsp_rdata"}, rsp_rdata[d], 32'h0);
        checkBit({name, "_rsp_err"}, rsp_err[d], 1'b0);
    endtask

    initial begin
        int          n;
        logic [31:0] rd;
        logic        er;
        logic        we;
        logic        uns;
        logic [31:0] addr;
        logic [1:0]  size;

        for (int d = 0; d < 2; d++) begin
            rst[d]          = 1'b1;
            req_valid[d]    = 1'b0;
            req_we[d]       = 1'b0;
            req_addr[d]     = 32'h0;
            req_wdata[d]    = 32'h0;
            req_size[d]     = 2'b00;
            req_unsigned[d] = 1'b0;
            rsp_ready[d]    = 1'b1;
            busy[d]         = 1'b0;
            inResp[d]       = 1'b0;
            lat[d]          = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        checkIdle("reset0", 0);
        checkIdle("reset1", 1);
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        $display("[TB] directed word/byte/half accesses");
        expectTxn("st_w10",    0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b00, 1'b0, 32'h0,        1'b0);
        expectTxn("ld_w10",    0, 1'b0, 32'h10, 32'h0,        2'b00, 1'b0, 32'hDEADBEEF, 1'b0);
        expectTxn("st_b13",    0, 1'b1, 32'h13, 32'h80,       2'b10, 1'b0, 32'h0,        1'b0);
        expectTxn("ld_b13_s",  0, 1'b0, 32'h13, 32'h0,        2'b10, 1'b0, 32'hFFFFFF80, 1'b0);
        expectTxn("ld_b13_u",  0, 1'b0, 32'h13, 32'h0,        2'b10, 1'b1, 32'h00000080, 1'b0);
        expectTxn("ld_w10_b",  0, 1'b0, 32'h10, 32'h0,        2'b00, 1'b1, 32'h80ADBEEF, 1'b0);
        expectTxn("st_w20",    0, 1'b1, 32'h20, 32'h0,        2'b00, 1'b0, 32'h0,        1'b0);
        expectTxn("st_h22",    0, 1'b1, 32'h22, 32'h1234,     2'b01, 1'b0, 32'h0,        1'b0);
        expectTxn("ld_w20",    0, 1'b0, 32'h20, 32'h0,        2'b00, 1'b0, 32'h12340000, 1'b0);
        expectTxn("st_h22_b",  0, 1'b1, 32'h22, 32'h8001,     2'b01, 1'b0, 32'h0,        1'b0);
        expectTxn("ld_h22_s",  0, 1'b0, 32'h22, 32'h0,        2'b01, 1'b0, 32'hFFFF8001, 1'b0);

        $display("[TB] error accesses");
        expectTxn("st_w21_mis", 0, 1'b1, 32'h21,        32'hFFFFFFFF, 2'b00, 1'b0, 32'h0, 1'b1);
        expectTxn("ld_h23_mis", 0, 1'b0, 32'h23,        32'h0,        2'b01, 1'b0, 32'h0, 1'b1);
        expectTxn("st_oor",     0, 1'b1, 32'(4*DEPTH),  32'h55555555, 2'b00, 1'b0, 32'h0, 1'b1);
        expectTxn("ld_w20_b",   0, 1'b0, 32'h20,        32'h0,        2'b00, 1'b0, 32'h80010000, 1'b0);

        $display("[TB] response backpressure");
        pushExp(0, modelAccess(0, 1'b0, 32'h10, 32'h0, 2'b00, 1'b0));
        applyStimulus(0, 1'b0, 32'h10, 32'h0, 2'b00, 1'b0);
        waitAccept(0, n);
        rsp_ready[0] = 1'b0;
        pushExp(0, modelAccess(0, 1'b0, 32'h20, 32'h0, 2'b00, 1'b0));
        applyStimulus(0, 1'b0, 32'h20, 32'h0, 2'b00, 1'b0);
        n = 0;
        while (!rsp_valid[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (5) begin
            @(negedge clk);
            checkBit("bp_req_ready", req_ready[0], 1'b0);
            checkBit("bp_rsp_valid", rsp_valid[0], 1'b1);
            checkOutput("bp_rsp_rdata", rsp_rdata[0], 32'h80ADBEEF);
        end
        @(posedge clk);
        #1;
        rsp_ready[0] = 1'b1;
        waitResp(0, 1'b0, rd, er);
        checkOutput("bp_first_rdata", rd, 32'h80ADBEEF);
        waitAccept(0, n);
        checkOutput("bp_accept_delay", 32'(n), 32'd1);
        waitResp(0, 1'b0, rd, er);
        checkOutput("bp_second_rdata", rd, 32'h80010000);

        $display("[TB] reset during wait state");
        expectTxn("st_w30_clr", 0, 1'b1, 32'h30, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0);
        applyStimulus(0, 1'b1, 32'h30, 32'hCAFEBABE, 2'b00, 1'b0);
        waitAccept(0, n);
        rst[0] = 1'b1;
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        checkIdle("abort", 0);
        expectTxn("ld_w30", 0, 1'b0, 32'h30, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0);

        $display("[TB] zero wait states");
        expectTxn("w0_st_w10",   1, 1'b1, 32'h10, 32'hDEADBEEF, 2'b00, 1'b0, 32'h0,        1'b0);
        expectTxn("w0_ld_w10",   1, 1'b0, 32'h10, 32'h0,        2'b00, 1'b0, 32'hDEADBEEF, 1'b0);
        expectTxn("w0_st_b13",   1, 1'b1, 32'h13, 32'h80,       2'b10, 1'b0, 32'h0,        1'b0);
        expectTxn("w0_ld_b13_s", 1, 1'b0, 32'h13, 32'h0,        2'b10, 1'b0, 32'hFFFFFF80, 1'b0);

        $display("[TB] randomized traffic");
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < DEPTH; w++) begin
                runTxn(d, 1'b1, 32'(4*w), $urandom, 2'b00, 1'b0, 1'b0, rd, er);
            end
            for (int i = 0; i < 150; i++) begin
                we   = 1'($urandom_range(0, 1));
                uns  = 1'($urandom_range(0, 1));
                size = 2'($urandom_range(0, 3));
                addr = 32'($urandom_range(0, 4*DEPTH + 15));
                if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
                runTxn(d, we, addr, $urandom, size, uns, 1'b1, rd, er);
            end
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/data_mem_resp.md
Name: data_mem_resp

Overview:
- Responder end of the processor's data-memory interface: accepts load/store requests from a load/store initiator over a valid/ready handshake and returns load data or store completion over a second valid/ready channel.
- Holds the word-organised, little-endian data RAM; performs byte/half/word lane selection, store byte-enables and load sign/zero extension internally.
- Inserts a programmable number of wait states so the multi-cycle pipeline can be exercised against non-zero memory latency.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the RAM; valid byte addresses are 0 .. 4*DEPTH_WORDS-1
- WAIT_CYCLES, 2, wait-state cycles between request acceptance and response; 0 allowed

Ports:
- clk  input  1  clock; all logic on the rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request
- req_we  input  1  1 = store, 0 = load
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned: byte in [7:0], half in [15:0]
- req_size  input  2  00 word, 01 half, 10 byte, 11 treated as word
- req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend
- rsp_valid  output  1  response present
- rsp_ready  input  1  initiator accepts the response
- rsp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors
- rsp_err  output  1  misaligned or out-of-range access

Behaviour:
- Reset:
  - Synchronous, active-high; one clk with rst=1 forces state IDLE, wait counter 0, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - RAM contents are not cleared.
  - Reset mid-transaction abandons the transaction; a store not yet committed is never written.
- FSM IDLE -> WAIT -> RESP -> IDLE:
  - IDLE: req_ready=1. When req_valid=1, capture we/addr/wdata/size/unsigned. Go to WAIT with counter=WAIT_CYCLES-1, or directly to RESP when WAIT_CYCLES=0.
  - WAIT: req_ready=0. Decrement the counter each cycle; when the counter is 0, go to RESP.
  - RESP: rsp_valid=1. rsp_rdata and rsp_err hold stable until rsp_valid and rsp_ready are both 1 in the same cycle; then go to IDLE and drop rsp_valid.
- Timing:
  - The access (store commit or RAM read) happens on the edge that enters RESP.
  - rsp_valid rises exactly WAIT_CYCLES+1 cycles after the accept edge.
  - Back-to-back throughput is one transaction per WAIT_CYCLES+2 cycles when rsp_ready is held at 1.
  - req_ready is 0 in WAIT and RESP; requests presented then are not accepted and must be held by the initiator.
- Addressing:
  - Word index = addr[31:2]; byte lane = addr[1:0].
  - Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
  - Out of range: addr >= 4*DEPTH_WORDS.
  - Either condition gives rsp_err=1 and rsp_rdata=0, and a store performs no RAM write.
- Stores:
  - Byte: writes wdata[7:0] into lane addr[1:0].
  - Half: writes wdata[15:0] into lanes addr[1]*2 and addr[1]*2+1.
  - Word: writes all four lanes.
  - Unselected lanes are unchanged.
  - Response carries rsp_rdata=0, rsp_err=0.
- Loads:
  - Select the byte or half at the same lane positions as stores.
  - Extend to 32 bits per req_unsigned; for word loads req_unsigned is ignored.
- Simultaneous events:
  - In RESP with rsp_ready=1 and req_valid=1, the new request is not accepted in that cycle; it is accepted the following cycle in IDLE.
  - A load following a store to the same address returns the stored data.

Test Plan:
- Reset, WAIT_CYCLES=2: store word 0xDEADBEEF to 0x10, then load word from 0x10 -> rsp_valid rises 3 cycles after each accept, rsp_rdata=0xDEADBEEF, rsp_err=0.
- Store byte 0x80 to 0x13, then load byte signed and unsigned from 0x13 -> 0xFFFFFF80 and 0x00000080; load word 0x10 -> 0x80ADBEEF.
- Store half 0x1234 to 0x22 over word 0 at 0x20, then load word 0x20 -> 0x12340000. Load half signed from 0x22 after storing 0x8001 there -> 0xFFFF8001.
- Misaligned word store to 0x21 and half load from 0x23, plus a store to 4*DEPTH_WORDS -> rsp_err=1, rsp_rdata=0, and a subsequent load of 0x20 is unchanged.
- Response backpressure: hold rsp_ready=0 for 5 cycles with req_valid=1 -> rsp_valid and rsp_rdata stable, req_ready=0, nothing accepted. Then rsp_ready=1 -> pending request accepted one cycle after the handshake.
- Assert rst during WAIT of a store to 0x30 (prior contents 0x0) -> next cycle req_ready=1 and rsp_valid=0; a subsequent load of 0x30 -> 0x00000000. Repeat the first scenario with WAIT_CYCLES=0 -> rsp_valid one cycle after accept.
